// File: rtl/signed_restoring_divider_if.sv
// rtl/signed_restoring_divider_if.sv - request/operand/result bundle for the signed restoring divider
interface signed_restoring_divider_if;
    logic       start;
    logic [9:0] data_in;
    logic       done;
    logic [9:0] quotient;
    logic [4:0] remainder;
    logic       div0;
    logic       ovf;

    modport master (
        output start,
        output data_in,
        input  done,
        input  quotient,
        input  remainder,
        input  div0,
        input  ovf
    );

    modport slave (
        input  start,
        input  data_in,
        output done,
        output quotient,
        output remainder,
        output div0,
        output ovf
    );
endinterface

// File: rtl/signed_restoring_divider.sv
// rtl/signed_restoring_divider.sv - 10-bit by 5-bit signed restoring divider, fixed 14-cycle latency
module signed_restoring_divider (
    input  logic                        clk,
    input  logic                        rst,
    signed_restoring_divider_if.slave   bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_B = 3'd1;
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] ITER   = 3'd3;
    localparam logic [2:0] FIX    = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0] state;
    logic [2:0] state_nxt;

    logic ld_a;
    logic ld_b;
    logic ld_mag;
    logic do_iter;
    logic do_fix;
    logic set_div0;
    logic clr_flags;

    logic b_zero;
    logic a_neg;
    logic b_neg;
    logic borrow;
    logic cnt_last;
    logic ovf_case;

    logic [9:0] a_reg;
    logic [4:0] b_reg;
    logic [9:0] aq;
    logic [4:0] b_mag;
    logic [5:0] pr;
    logic [3:0] cnt;
    logic [9:0] q_reg;
    logic [4:0] r_reg;
    logic       div0_reg;
    logic       ovf_reg;

    logic [5:0] pr_shift;
    logic [6:0] diff;
    logic [9:0] q_fixed;
    logic [4:0] r_fixed;

    // ---------------- control path ----------------
    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_mag    = 1'b0;
        do_iter   = 1'b0;
        do_fix    = 1'b0;
        set_div0  = 1'b0;
        clr_flags = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    ld_a      = 1'b1;
                    clr_flags = 1'b1;
                    state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                ld_b      = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                if (b_zero) begin
                    set_div0  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    ld_mag    = 1'b1;
                    state_nxt = ITER;
                end
            end
            ITER: begin
                do_iter = 1'b1;
                if (cnt_last) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                do_fix    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                if (!bus.start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- datapath status ----------------
    assign b_zero   = (b_reg == 5'd0);
    assign a_neg    = a_reg[9];
    assign b_neg    = b_reg[4];
    assign cnt_last = (cnt == 4'd1);
    assign ovf_case = (a_reg == 10'h200) && (b_reg == 5'h1F);

    // Partial remainder stays below the divisor magnitude (<=16), so its top bit is free for the shift.
    assign pr_shift = {pr[4:0], aq[9]};
    assign diff     = {1'b0, pr_shift} - {2'b00, b_mag};
    assign borrow   = diff[6];

    // Quotient magnitude of 512 negates onto itself, which is exactly the -512/1 answer.
    assign q_fixed  = (a_neg ^ b_neg) ? (~aq + 10'd1) : aq;
    assign r_fixed  = a_neg ? (~pr[4:0] + 5'd1) : pr[4:0];

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= 10'd0;
            b_reg <= 5'd0;
            aq    <= 10'd0;
            b_mag <= 5'd0;
            pr    <= 6'd0;
            cnt   <= 4'd0;
        end else begin
            if (ld_a) begin
                a_reg <= bus.data_in;
            end
            if (ld_b) begin
                b_reg <= bus.data_in[4:0];
            end
            if (ld_mag) begin
                aq    <= a_neg ? (~a_reg + 10'd1) : a_reg;
                b_mag <= b_neg ? (~b_reg + 5'd1) : b_reg;
                pr    <= 6'd0;
                cnt   <= 4'd10;
            end else if (do_iter) begin
                pr  <= borrow ? pr_shift : diff[5:0];
                aq  <= {aq[8:0], ~borrow};
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg    <= 10'd0;
            r_reg    <= 5'd0;
            div0_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            if (clr_flags) begin
                div0_reg <= 1'b0;
                ovf_reg  <= 1'b0;
            end
            if (set_div0) begin
                q_reg    <= 10'd0;
                r_reg    <= 5'd0;
                div0_reg <= 1'b1;
                ovf_reg  <= 1'b0;
            end
            if (do_fix) begin
                if (ovf_case) begin
                    q_reg   <= 10'h200;
                    r_reg   <= 5'd0;
                    ovf_reg <= 1'b1;
                end else begin
                    q_reg   <= q_fixed;
                    r_reg   <= r_fixed;
                    ovf_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.done      = (state == DONE);
    assign bus.quotient  = q_reg;
    assign bus.remainder = r_reg;
    assign bus.div0      = div0_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_signed_restoring_divider.sv
// tb/tb_signed_restoring_divider.sv - scoreboard bench for signed_restoring_divider
module tb_signed_restoring_divider;
    logic clk;
    logic rst;

    signed_restoring_divider_if bus ();

    signed_restoring_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [9:0] q;
        logic [4:0] r;
        logic       d0;
        logic       ov;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   done_rises;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial done_rises = 0;
    always @(posedge bus.done) done_rises = done_rises + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input logic [9:0] a, input logic [4:0] b);
        exp_t e;
        int   sa;
        int   sd;
        sa = int'($signed(a));
        sd = int'($signed(b));
        if (sd == 0) begin
            e.q = 10'd0; e.r = 5'd0; e.d0 = 1'b1; e.ov = 1'b0; e.lat = 3;
        end else if (sa == -512 && sd == -1) begin
            e.q = 10'h200; e.r = 5'd0; e.d0 = 1'b0; e.ov = 1'b1; e.lat = 14;
        end else begin
            e.q = 10'(sa / sd); e.r = 5'(sa % sd); e.d0 = 1'b0; e.ov = 1'b0; e.lat = 14;
        end
        sb.push_back(e);
    endtask

    task automatic do_div(input logic [9:0] a, input logic [4:0] b, input int hold);
        exp_t e;
        int   n;
        int   rises0;
        push_model(a, b);
        rises0 = done_rises;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = a;
        @(negedge clk);
        chk("div0_clr", bus.div0, 0);
        chk("ovf_clr", bus.ovf, 0);
        bus.data_in = {5'($urandom), b};
        @(negedge clk);
        bus.data_in = 10'($urandom);
        n = 2;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        e = sb.pop_front();
        chk("done", bus.done, 1);
        chk("latency", n, e.lat);
        chk("quot", bus.quotient, e.q);
        chk("rem", bus.remainder, e.r);
        chk("div0", bus.div0, e.d0);
        chk("ovf", bus.ovf, e.ov);
        repeat (hold) @(negedge clk);
        chk("done_hold", bus.done, 1);
        chk("quot_stable", bus.quotient, e.q);
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_drop", bus.done, 0);
        chk("quot_idle", bus.quotient, e.q);
        chk("rem_idle", bus.remainder, e.r);
        chk("one_done", done_rises - rises0, 1);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = 10'd0;
        #12;
        chk("rst_done", bus.done, 0);
        chk("rst_quot", bus.quotient, 0);
        chk("rst_rem", bus.remainder, 0);
        chk("rst_flags", {bus.div0, bus.ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", bus.done, 0);

        do_div(10'b1110110110, 5'd13, 1);
        do_div(10'd300, 5'b11001, 1);
        do_div(10'd100, 5'd0, 1);
        do_div(10'h200, 5'h1F, 1);
        do_div(10'h200, 5'h10, 1);

        // Abort a request during its fifth ITER cycle.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 10'd300;
        @(negedge clk);
        bus.data_in = 10'b0000011001;
        repeat (6) @(negedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_quot", bus.quotient, 0);
        chk("mid_rst_rem", bus.remainder, 0);
        chk("mid_rst_flags", {bus.div0, bus.ovf}, 0);
        chk("mid_rst_state", dut.state, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", bus.done, 0);
        do_div(10'd0, 5'd5, 1);

        for (int i = 0; i < 8; i++) begin
            do_div(10'($urandom), 5'($urandom), 1);
        end

        do_div(10'd123, 5'd7, 26);
        @(negedge clk);
        chk("no_retrigger", bus.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/signed_restoring_divider.md
SIGNED_RESTORING_DIVIDER -- requirements
Module: signed_restoring_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; level-sensitive.
REQ-004 SHALL have port data_in, input, 10 bits: shared operand bus, two's complement.
REQ-005 SHALL have port done, output, 1 bit: result valid.
REQ-006 SHALL have port quotient, output, 10 bits: signed quotient, truncated toward zero.
REQ-007 SHALL have port remainder, output, 5 bits: signed remainder, same sign as the dividend.
REQ-008 SHALL have port div0, output, 1 bit: divisor was zero.
REQ-009 SHALL have port ovf, output, 1 bit: quotient not representable in 10 bits.

Function
REQ-010 SHALL implement a datapath/controlpath split: the FSM drives load, shift, subtract/restore, count and fix-up controls; the datapath returns zero-detect, sign and borrow status.
REQ-011 SHALL use FSM states IDLE, LOAD_B, CHECK, ITER, FIX and DONE.
REQ-012 IDLE with start=1 SHALL capture data_in[9:0] as the dividend at the sampling edge (edge 1) and move to LOAD_B.
REQ-013 LOAD_B SHALL capture data_in[4:0] as the divisor at edge 2, ignore data_in[9:5], and move to CHECK.
REQ-014 CHECK (edge 3) with divisor == 0 SHALL go to DONE with div0=1, quotient=0, remainder=0 and ovf=0.
REQ-015 CHECK (edge 3) with divisor != 0 SHALL load the magnitudes (dividend 10-bit unsigned, divisor 5-bit unsigned, so 512 and 16 are representable), clear a 6-bit partial remainder, set the counter to 10 and go to ITER.
REQ-016 Each ITER cycle SHALL do the following: shift the partial remainder left, bringing in the dividend MSB; trial-subtract the divisor magnitude; if no borrow, keep the result and shift quotient bit 1 in, else restore and shift 0 in; decrement the counter.
REQ-017 ITER SHALL run exactly 10 cycles (edges 4..13) and then go to FIX.
REQ-018 FIX (edge 14) SHALL negate the quotient if the operand signs differ and negate the remainder if the dividend is negative, then go to DONE.
REQ-019 FIX SHALL handle the one unrepresentable case, dividend=-512 with divisor=-1: it SHALL set ovf=1, quotient=10'h200 and remainder=0.
REQ-020 Latency SHALL be fixed: done=1 after edge 14 (edge 3 for div0), counting the start-sampling edge as edge 1, independent of operand values.
REQ-021 DONE SHALL hold done=1 and the results stable while start=1, and SHALL return to IDLE at the first edge with start=0.
REQ-022 A new request SHALL be accepted only from IDLE, so start held high does not retrigger.
REQ-023 quotient, remainder, div0 and ovf SHALL be registered and SHALL hold their last values through IDLE until the next CHECK/FIX update.
REQ-024 div0 and ovf SHALL clear when a new request is accepted in IDLE.
REQ-025 done SHALL be 1 only in DONE, driven from state with no combinational path from inputs.
REQ-026 start and data_in SHALL be ignored in LOAD_B..FIX, except that data_in is sampled in LOAD_B.

Reset
REQ-027 rst=1 SHALL immediately force IDLE with done=0, quotient=0, remainder=0, div0=0, ovf=0, and all internal registers cleared, in any state including mid-ITER.
REQ-028 After rst is released, the block SHALL accept a request only at a rising edge where start=1 in IDLE, with no stale result or partial state surviving.

Verification
REQ-029 Dividend 10'b1110110110 (-74), then divisor 5'd13: done after edge 14, quotient=-5 (10'h3FB), remainder=-9 (5'h17), div0=0, ovf=0.
REQ-030 Dividend 300, then divisor 5'b11001 (-7): quotient=-42 (10'h3D6), remainder=6 (5'h06).
REQ-031 Dividend 100, then divisor 0: done after edge 3, div0=1, quotient=0, remainder=0.
REQ-032 Dividend 10'h200 (-512), then divisor 5'h1F (-1): ovf=1, quotient=10'h200, remainder=0; then dividend -512 with divisor 5'h10 (-16): quotient=32, remainder=0, ovf=0.
REQ-033 Assert rst during the 5th ITER cycle: all outputs are 0 immediately, the FSM is in IDLE, and a following 0/5 request gives quotient=0, remainder=0 at edge 14.
REQ-034 Hold start=1 for 40 cycles: exactly one done assertion, and done stays high until start drops, then the FSM returns to IDLE on the next edge.
